alu_mc: RTL
===========

# alu_mc

Parametrised multi-cycle successor to the combinational ALU. It adds a start/busy/done handshake, registered results and NZCV flags, variable-distance shifts, an iterative multiply and an unsigned divide/remainder. It sits between the data/address buses and the result bus. The result is driven onto a shared tri-state bus under `oe`.

## Interface
- `WIDTH`, default 32: operand/result width; must be a power of two, ≥ 8.
- `SHW`, default $clog2(WIDTH): width of the shift-amount field taken from `b`.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  reset; one clock, synchronous, active-low.
- `start`  in  1  request; accepted only when `busy`=0.
- `op`  in  4  0 PASSA, 1 PASSB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 ADD, 7 ADDC, 8 SUB, 9 SUBB, 10 SHL, 11 SHR, 12 ASHR, 13 MUL, 14 DIVU, 15 REMU.
- `carry_in`  in  1  carry for ADDC/SUBB; sampled at accept.
- `a`  in  WIDTH  operand A (data bus); sampled at accept.
- `b`  in  WIDTH  operand B (address bus); shift ops use `b[SHW-1:0]`.
- `oe`  in  1  output enable, combinational.
- `out`  out (tri)  WIDTH  `oe` ? result register : high-Z.
- `status`  out  4  registered {N,Z,C,V}.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Operands, `op` and `carry_in` are latched on the accepting edge (`start`=1 and `busy`=0).
- FSM has two states: IDLE and RUN.
  - IDLE + start, single-cycle op (0–9): the result and status are written on that edge. The FSM stays in IDLE and `done`=1 next cycle.
  - IDLE + start, shift (10–12) with amount n>0, or MUL/DIVU/REMU: go to RUN with the iteration counter loaded.
  - Shift with n=0: completes like a single-cycle op.
  - RUN: one iteration per cycle. On the last iteration, result and status are written, the FSM returns to IDLE and `done` pulses next cycle.
- Shifts move one bit per cycle for n iterations.
  - SHL fills with 0.
  - SHR fills with 0.
  - ASHR fills with `a[WIDTH-1]`.
- MUL is shift-add over WIDTH iterations. Result = low WIDTH bits of a*b (unsigned).
- DIVU/REMU use restoring division over WIDTH iterations. Result = a/b or a%b (unsigned).
- Arithmetic is done at WIDTH+1 bits; bit WIDTH is the carry.
  - ADD: a+b.
  - ADDC: a+b+carry_in.
  - SUB: a+~b+1.
  - SUBB: a+~b+carry_in.
  - For SUB/SUBB, C=1 means no borrow.
- Flags, written only at completion:
  - N = result[WIDTH-1]; Z = (result==0).
  - V for add ops = (a[msb]==b[msb]) & (r[msb]!=a[msb]).
  - V for sub ops = (a[msb]!=b[msb]) & (r[msb]!=a[msb]).
  - C for shifts = last bit shifted out; n=0 leaves C unchanged. V=0 for shifts.
  - MUL: C = (high product half != 0), V=0.
  - Logic and pass ops: C=0, V=0.
- Divide by zero is not an error stall.
  - DIVU result = all ones; REMU result = a.
  - C=0, V=1; full WIDTH iterations are still taken.
- `start` while `busy`=1 is ignored: no queueing, no effect on the op in flight.
- The result register holds its value until the next completion. `out` reflects it whenever `oe`=1, including while busy.

## Timing
- Reset (`rst_n`=0 at an edge):
  - FSM → IDLE; result = 0; status = 4'b0000; `busy`=0; `done`=0.
  - Any in-flight op is aborted with no `done`.
- `busy`=1 exactly while in RUN. It is registered, so it rises the cycle after an accepting edge.
- Latency is measured from the accepting edge to the edge after which `done`=1:
  - 1 cycle for single-cycle ops and n=0 shifts.
  - n+1 cycles for shifts with n>0.
  - WIDTH+1 cycles for MUL/DIVU/REMU (33 at WIDTH=32).
- `done` is high for exactly one cycle, with `busy`=0 in that cycle. A `start` in the `done` cycle is accepted, giving back-to-back ops.
- Single-cycle ops may be issued every cycle; `done` then stays high continuously, one pulse per op.
- `out` and its high-Z transitions are purely combinational on `oe` and the result register.

## Test plan
- Reset mid-op:
  - Start MUL with a=3, b=5, then assert `rst_n`=0 on cycle 4.
  - Expect: no `done`; result 0; status 0; `busy`=0; next `start` accepted.
- Carry/overflow flags (WIDTH=32):
  - ADD with a=0x7FFFFFFF, b=1 → result 0x80000000, NZCV=1001, `done` at latency 1.
  - SUB with a=b=5 → result 0, NZCV=0110.
- ASHR with a=0x80000010, b=4:
  - `busy` high for 4 cycles; `done` at latency 5.
  - Result 0xF8000001, C=0, N=1.
- MUL with a=0xFFFFFFFF, b=2:
  - Result 0xFFFFFFFE, C=1.
  - Latency 33; `busy` high for 32 cycles.
- Divide:
  - DIVU with a=100, b=7 → 14; REMU with the same operands → 2.
  - DIVU with b=0 → 0xFFFFFFFF, V=1.
- Handshake and bus:
  - `start` pulsed during `busy` is ignored.
  - A `start` in the `done` cycle is accepted.
  - `oe`=0 gives `out` = Z; `oe`=1 gives the last result.
  - WIDTH=8 regression: SHL of 0x81 by 1 → 0x02, C=1.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with a start/busy/done handshake, registered result
// and NZCV flags, iterative shifts, shift-add multiply and restoring divide.
// The result drives a shared tri-state bus whenever oe is high.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             oe,
    output tri   [WIDTH-1:0] out,
    output logic [3:0]       status,
    output logic             busy,
    output logic             done
);

    localparam int LOGW = $clog2(WIDTH);
    localparam int CW   = ((SHW > LOGW) ? SHW : LOGW) + 1;

    typedef enum logic [3:0] {
        OP_PASSA = 4'd0,  OP_PASSB = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
        OP_XOR   = 4'd4,  OP_NOT   = 4'd5,  OP_ADD  = 4'd6,  OP_ADDC = 4'd7,
        OP_SUB   = 4'd8,  OP_SUBB  = 4'd9,  OP_SHL  = 4'd10, OP_SHR  = 4'd11,
        OP_ASHR  = 4'd12, OP_MUL   = 4'd13, OP_DIVU = 4'd14, OP_REMU = 4'd15
    } op_e;

    typedef enum logic {IDLE, RUN} state_e;

    state_e           state, state_next;
    op_e              op_q;
    logic [WIDTH-1:0] work;     // shift value / multiplier+product low / dividend+quotient
    logic [WIDTH-1:0] acc;      // product high half / partial remainder
    logic [WIDTH-1:0] opb;      // latched multiplicand / divisor
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic             done_q;

    logic             accept, launch, finish_run;
    logic [SHW-1:0]   shamt;
    logic             is_shift;

    logic             sub_op, cin;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c, sc_v;

    logic [WIDTH-1:0] work_nx, acc_nx;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_rem;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge, shift_c;
    logic [WIDTH-1:0] rn_res;
    logic             rn_c, rn_v;

    assign shamt    = b[SHW-1:0];
    assign is_shift = (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASHR);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and handshake control
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        launch     = 1'b0;
        finish_run = 1'b0;
        if (state == IDLE) begin
            if (start) begin
                accept = 1'b1;
                if (op >= OP_MUL || (is_shift && shamt != '0)) begin
                    launch     = 1'b1;
                    state_next = RUN;
                end
            end
        end else if (cnt == CW'(1)) begin
            finish_run = 1'b1;
            state_next = IDLE;
        end
    end

    // Single-cycle result and flags, computed from the live inputs at accept
    always_comb begin
        sub_op = (op == OP_SUB) || (op == OP_SUBB);
        addend = sub_op ? ~b : b;
        case (op)
            OP_ADDC, OP_SUBB: cin = carry_in;
            OP_SUB:           cin = 1'b1;
            default:          cin = 1'b0;
        endcase
        sum    = {1'b0, a} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};
        sc_res = a;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        case (op)
            OP_PASSA: sc_res = a;
            OP_PASSB: sc_res = b;
            OP_AND:   sc_res = a & b;
            OP_OR:    sc_res = a | b;
            OP_XOR:   sc_res = a ^ b;
            OP_NOT:   sc_res = ~a;
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBB: begin
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
                sc_v   = (sub_op ? (a[WIDTH-1] != b[WIDTH-1]) : (a[WIDTH-1] == b[WIDTH-1]))
                         & (sum[WIDTH-1] != a[WIDTH-1]);
            end
            // zero-distance shift: value passes through, carry keeps its old value
            default: begin
                sc_res = a;
                sc_c   = flags[1];
            end
        endcase
    end

    // One iteration of the multi-cycle datapath plus its final result/flags
    always_comb begin
        work_nx  = work;
        acc_nx   = acc;
        shift_c  = 1'b0;
        mul_sum  = {1'b0, acc} + (work[0] ? {1'b0, opb} : '0);
        div_rem  = {acc, work[WIDTH-1]};
        div_ge   = (div_rem >= {1'b0, opb});
        // remainder stays below 2*divisor, so the low WIDTH bits hold the difference
        div_diff = div_rem[WIDTH-1:0] - opb;
        case (op_q)
            OP_SHL: begin
                shift_c = work[WIDTH-1];
                work_nx = {work[WIDTH-2:0], 1'b0};
            end
            OP_SHR: begin
                shift_c = work[0];
                work_nx = {1'b0, work[WIDTH-1:1]};
            end
            OP_ASHR: begin
                shift_c = work[0];
                work_nx = {work[WIDTH-1], work[WIDTH-1:1]};
            end
            OP_MUL: {acc_nx, work_nx} = {mul_sum, work[WIDTH-1:1]};
            OP_DIVU, OP_REMU: begin
                acc_nx  = div_ge ? div_diff : div_rem[WIDTH-1:0];
                work_nx = {work[WIDTH-2:0], div_ge};
            end
            default: ;
        endcase
        rn_res = work_nx;
        rn_c   = 1'b0;
        rn_v   = 1'b0;
        case (op_q)
            OP_SHL, OP_SHR, OP_ASHR: rn_c = shift_c;
            OP_MUL:  rn_c = (acc_nx != '0);
            OP_DIVU: rn_v = (opb == '0);
            OP_REMU: begin
                rn_res = acc_nx;
                rn_v   = (opb == '0);
            end
            default: ;
        endcase
    end

    // Operand latching, iteration registers, result/flags and done pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q   <= OP_PASSA;
            work   <= '0;
            acc    <= '0;
            opb    <= '0;
            cnt    <= '0;
            result <= '0;
            flags  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                op_q <= op_e'(op);
                work <= a;
                acc  <= '0;
                opb  <= b;
                cnt  <= is_shift ? CW'(shamt) : CW'(WIDTH);
                if (!launch) begin
                    result <= sc_res;
                    flags  <= {sc_res[WIDTH-1], (sc_res == '0), sc_c, sc_v};
                    done_q <= 1'b1;
                end
            end else if (state == RUN) begin
                work <= work_nx;
                acc  <= acc_nx;
                cnt  <= cnt - CW'(1);
                if (finish_run) begin
                    result <= rn_res;
                    flags  <= {rn_res[WIDTH-1], (rn_res == '0), rn_c, rn_v};
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy   = (state == RUN);
    assign done   = done_q;
    assign status = flags;
    assign out    = oe ? result : 'z;

endmodule
